dual_port_ram_be: RTL and testbench

Parametrised simple dual-port RAM, the next generation of the FIFO storage array. Adds byte-lane write enables, an explicit read enable with a `q_valid` strobe, a selectable same-address collision mode and an optional output pipeline register. It is the storage element under the next FIFO revision and any buffer that needs partial-word writes. One write port and one read port, both on the single clock.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_byte_lane.sv | 45 ++++
 rtl/dual_port_ram_be.sv | 96 +++++++++
 tb/tb_dual_port_ram_be.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and helpers for the byte-lane dual-port RAM family.
package ram_pkg;

  // Collision behaviour selectors for same-address read/write on one edge
  localparam int unsigned RD_MODE_READ_OLD   = 0;
  localparam int unsigned RD_MODE_WRITE_THRU = 1;

  // Number of write lanes in a word
  function automatic int unsigned calc_nb(input int unsigned data_width,
                                          input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_byte_lane.sv
// One byte lane: simple dual-port array with registered read and collision rule.
module ram_byte_lane
  import ram_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RD_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [BYTE_WIDTH-1:0] d,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [BYTE_WIDTH-1:0] q
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];
  logic                  bypass_c;

  // Write-through forwards the incoming byte when both ports hit the same word
  always_comb begin
    bypass_c = (RD_MODE == RD_MODE_WRITE_THRU) && we && (w_addr == r_addr);
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= d;
    end
  end

  // Read data register; holds when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (re) begin
      q <= bypass_c ? d : mem[r_addr];
    end
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane writes, read strobe and optional output stage.
module dual_port_ram_be
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned RD_MODE    = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         we,
  input  logic [calc_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]                        w_addr,
  input  logic [DATA_WIDTH-1:0]                        d,
  input  logic                                         re,
  input  logic [ADDR_WIDTH-1:0]                        r_addr,
  output logic [DATA_WIDTH-1:0]                        q,
  output logic                                         q_valid
);

  localparam int unsigned NB = calc_nb(DATA_WIDTH, BYTE_WIDTH);

  // Parameter sanity checks at elaboration
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_MODE > 1) begin : g_bad_rd_mode
    $error("RD_MODE must be 0 or 1");
  end
  if (OUT_REG > 1) begin : g_bad_out_reg
    $error("OUT_REG must be 0 or 1");
  end

  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] lane_q;
  logic                  s1_valid;

  // Writes presented while reset is asserted are dropped
  always_comb begin
    wr_en_c = we & rst_n;
  end

  // Per-lane storage with its own write enable
  for (genvar i = 0; i < NB; i++) begin : g_lane
    ram_byte_lane #(
      .BYTE_WIDTH(BYTE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RD_MODE   (RD_MODE)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en_c & be[i]),
      .w_addr(w_addr),
      .d     (d[i*BYTE_WIDTH +: BYTE_WIDTH]),
      .re    (re),
      .r_addr(r_addr),
      .q     (lane_q[i*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  // Stage-1 valid tracks the read strobe one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= re;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_q;
    logic                  s2_valid;

    // Output stage captures only words that carry a valid read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_q     <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_q <= lane_q;
        end
      end
    end

    assign q       = s2_q;
    assign q_valid = s2_valid;
  end else begin : g_no_out_reg
    assign q       = lane_q;
    assign q_valid = s1_valid;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed and scoreboard-checked bench covering five parameter sets on shared stimulus.
module tb_dual_port_ram_be;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [2:0]  w_addr;
  logic [2:0]  r_addr;
  logic [31:0] d;

  logic [7:0]  q_a, q_d;
  logic [31:0] q_b, q_c, q_e;
  logic        v_a, v_b, v_c, v_d, v_e;

  int checks   = 0;
  int failures = 0;
  bit model_on = 0;

  // Instance table: a=8b/old/lat1 b=32b/old/lat1 c=32b/thru/lat1 d=8b/thru/lat2 e=32b/old/lat2
  localparam int unsigned  NINST = 5;
  localparam bit           MODE   [NINST] = '{0, 0, 1, 1, 0};
  localparam bit           OUTREG [NINST] = '{0, 0, 0, 1, 1};
  localparam logic [31:0]  MASK   [NINST] = '{32'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF, 32'hFFFF_FFFF};

  logic [31:0] mem_m [8];
  logic [31:0] s1_q [NINST];
  logic        s1_v [NINST];
  logic [31:0] s2_q [NINST];
  logic        s2_v [NINST];

  dual_port_ram_be #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be[0:0]), .w_addr(w_addr), .d(d[7:0]),
    .re(re), .r_addr(r_addr), .q(q_a), .q_valid(v_a));
  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_MODE(0), .OUT_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .w_addr(w_addr), .d(d),
    .re(re), .r_addr(r_addr), .q(q_b), .q_valid(v_b));
  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_MODE(1), .OUT_REG(0)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .w_addr(w_addr), .d(d),
    .re(re), .r_addr(r_addr), .q(q_c), .q_valid(v_c));
  dual_port_ram_be #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_MODE(1), .OUT_REG(1)) u_d (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be[0:0]), .w_addr(w_addr), .d(d[7:0]),
    .re(re), .r_addr(r_addr), .q(q_d), .q_valid(v_d));
  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RD_MODE(0), .OUT_REG(1)) u_e (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .w_addr(w_addr), .d(d),
    .re(re), .r_addr(r_addr), .q(q_e), .q_valid(v_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] got_q(input int k);
    case (k)
      0:       return {24'h0, q_a};
      1:       return q_b;
      2:       return q_c;
      3:       return {24'h0, q_d};
      default: return q_e;
    endcase
  endfunction

  function automatic logic got_v(input int k);
    case (k)
      0:       return v_a;
      1:       return v_b;
      2:       return v_c;
      3:       return v_d;
      default: return v_e;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) r[l*8 +: 8] = d[l*8 +: 8];
    end
    return r;
  endfunction

  // Behavioural reference evaluated on each rising edge with the sampled inputs
  task automatic model_update();
    logic [31:0] old_r, new_w, rd;
    if (!rst_n) begin
      for (int k = 0; k < NINST; k++) begin
        s1_q[k] = '0; s1_v[k] = 1'b0; s2_q[k] = '0; s2_v[k] = 1'b0;
      end
      return;
    end
    old_r = mem_m[r_addr];
    new_w = merge(mem_m[w_addr]);
    for (int k = 0; k < NINST; k++) begin
      if (OUTREG[k]) begin
        if (s1_v[k]) s2_q[k] = s1_q[k];
        s2_v[k] = s1_v[k];
      end
      if (re) begin
        rd = (MODE[k] && we && (w_addr == r_addr)) ? new_w : old_r;
        s1_q[k] = rd & MASK[k];
      end
      s1_v[k] = re;
    end
    if (we) mem_m[w_addr] = new_w;
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) model_update();
    #1;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("rnd_q%0d", k), got_q(k), OUTREG[k] ? s2_q[k] : s1_q[k]);
      check($sformatf("rnd_v%0d", k), 32'(got_v(k)), OUTREG[k] ? 32'(s2_v[k]) : 32'(s1_v[k]));
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; be = 4'h0; w_addr = '0; r_addr = '0; d = '0;
    for (int k = 0; k < NINST; k++) begin
      s1_q[k] = '0; s1_v[k] = 1'b0; s2_q[k] = '0; s2_v[k] = 1'b0;
    end

    // Reset values
    step(); step();
    check("rst_q_a", 32'(q_a), 32'h0);
    check("rst_v_a", 32'(v_a), 32'h0);
    check("rst_q_d", 32'(q_d), 32'h0);
    check("rst_v_d", 32'(v_d), 32'h0);
    check("rst_q_e", q_e, 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_v_a", 32'(v_a), 32'h0);

    // Fill with 0xA5, then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; be = 4'hF; w_addr = 3'(i); d = 32'hA5;
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; r_addr = 3'(i);
      step();
      check($sformatf("fill_q_a%0d", i), 32'(q_a), 32'hA5);
      check($sformatf("fill_v_a%0d", i), 32'(v_a), 32'h1);
      check($sformatf("fill_q_b%0d", i), q_b, 32'hA5);
    end
    re = 1'b0;
    step();
    check("after_v_a", 32'(v_a), 32'h0);
    check("after_q_a", 32'(q_a), 32'hA5);

    // Partial-word write
    we = 1'b1; be = 4'hF; w_addr = 3'd2; d = 32'h1122_3344;
    step();
    be = 4'b0101; d = 32'hAABB_CCDD;
    step();
    we = 1'b0; re = 1'b1; r_addr = 3'd2;
    step();
    check("be_q_b", q_b, 32'h11BB_33DD);
    check("be_q_a", 32'(q_a), 32'hDD);
    re = 1'b0;

    // Same-address collision
    we = 1'b1; be = 4'hF; w_addr = 3'd5; d = 32'h0;
    step();
    be = 4'b0011; d = 32'hFFFF_FFFF; re = 1'b1; r_addr = 3'd5;
    step();
    check("coll_old_b", q_b, 32'h0);
    check("coll_thru_c", q_c, 32'h0000_FFFF);
    check("coll_old_a", 32'(q_a), 32'h0);
    we = 1'b0;
    step();
    check("coll_next_b", q_b, 32'h0000_FFFF);
    re = 1'b0;

    // Output-register latency
    we = 1'b1; be = 4'hF; w_addr = 3'd3; d = 32'h5A;
    step();
    we = 1'b0; re = 1'b1; r_addr = 3'd3;
    step();
    check("or_n_v_d", 32'(v_d), 32'h0);
    re = 1'b0;
    step();
    check("or_n1_q_d", 32'(q_d), 32'h5A);
    check("or_n1_v_d", 32'(v_d), 32'h1);
    check("or_n1_q_e", q_e, 32'h5A);
    step();
    check("or_n2_q_d", 32'(q_d), 32'h5A);
    check("or_n2_v_d", 32'(v_d), 32'h0);

    // Reset mid-burst; write during reset must be dropped
    re = 1'b1; r_addr = 3'd1;
    step();
    #2;
    rst_n = 1'b0;
    we = 1'b1; be = 4'hF; w_addr = 3'd0; d = 32'h77;
    #1;
    check("mid_q_a", 32'(q_a), 32'h0);
    check("mid_v_a", 32'(v_a), 32'h0);
    check("mid_q_d", 32'(q_d), 32'h0);
    check("mid_v_e", 32'(v_e), 32'h0);
    step(); step();
    we = 1'b0; re = 1'b0; rst_n = 1'b1;
    step();
    check("rel_v_a", 32'(v_a), 32'h0);
    check("rel_v_d", 32'(v_d), 32'h0);
    re = 1'b1; r_addr = 3'd0;
    step();
    check("rel_q_a", 32'(q_a), 32'hA5);
    check("rel_v_a1", 32'(v_a), 32'h1);
    check("rel_v_d1", 32'(v_d), 32'h0);
    re = 1'b0;
    step();
    check("rel_v_d2", 32'(v_d), 32'h1);
    check("rel_q_d2", 32'(q_d), 32'hA5);

    // Random traffic against the reference model
    model_on = 1'b1;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; be = 4'hF; w_addr = 3'(i); d = $urandom;
      step();
      compare_all();
    end
    for (int n = 0; n < 2000; n++) begin
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      w_addr = 3'($urandom_range(0, 7));
      d = $urandom;
      re = ($urandom_range(0, 9) < 7);
      r_addr = 3'($urandom_range(0, 7));
      step();
      compare_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
